spi_slv_periph: RTL and testbench

Memory-mapped SPI slave peripheral for the RISC-V MCU. It lets the CPU receive 32-bit words from an external SPI master, and it is the receiving counterpart of the MCU's SPI master peripheral. Serial bytes arrive LSB-byte-first and are packed into words, which go into a small RX FIFO that the CPU polls and pops with `lw`. An optional TX path shifts a CPU-written word out on `miso` in the same byte order.

---
 rtl/spi_slv_pkg.sv | 28 ++
 rtl/spi_slv_fifo.sv | 51 +++++
 rtl/spi_slv_periph.sv | 172 +++++++++++++++++
 tb/tb_spi_slv_periph.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slv_pkg.sv
// Shared register map, STATUS bit positions and helpers for the SPI slave peripheral.
package spi_slv_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [3:0] SPI_SLV_RXDATA = 4'h0;
  localparam logic [3:0] SPI_SLV_STATUS = 4'h4;
  localparam logic [3:0] SPI_SLV_TXDATA = 4'h8;

  localparam int unsigned ST_RX_VALID  = 0;
  localparam int unsigned ST_BUSY      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_TX_EMPTY  = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    REG_RXDATA = SPI_SLV_RXDATA[3:2],
    REG_STATUS = SPI_SLV_STATUS[3:2],
    REG_TXDATA = SPI_SLV_TXDATA[3:2],
    REG_RSVD   = 2'd3
  } reg_sel_e;

  // Word bit for serial position pos: byte pos[4:3], MSB-first inside the byte.
  function automatic logic [4:0] tx_bit_idx(input logic [4:0] pos);
    return {pos[4:3], ~pos[2:0]};
  endfunction

endpackage

// File: rtl/spi_slv_fifo.sv
// Synchronous word FIFO; push is ignored when full, pop is ignored when empty.
module spi_slv_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_slv_periph.sv
// Memory-mapped SPI mode-0 slave: packs LSB-byte-first words into an RX FIFO.
// Optional TX path on miso is enabled by defining SPI_SLV_PERIPH_TX_EN.
module spi_slv_periph
  import spi_slv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic              re,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        sck_sync, ss_sync, mosi_sync;
  logic              sck_s, ss_s, mosi_s, sck_d, ss_d;
  logic              sck_rise, ss_rise;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_idx;
  logic [7:0]        byte_sr;
  logic [WORD_W-1:0] word;
  logic [7:0]        byte_new;
  logic              push, pop, full, empty, overrun, tx_empty;
  logic [WORD_W-1:0] head;
  logic [CW-1:0]     count;
  reg_sel_e          sel;
  logic              unused_addr;

  assign sck_s    = sck_sync[1];
  assign ss_s     = ss_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign byte_new = {byte_sr[6:0], mosi_s};
  assign push     = sck_rise & ~ss_s & (bit_cnt == 3'd7) & (byte_idx == 2'd3);
  assign sel      = reg_sel_e'(addr[3:2]);
  assign pop      = re & (sel == REG_RXDATA) & ~empty;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  // ss resets high so a reset never looks like a selected transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      ss_sync   <= {ss_sync[0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      byte_idx <= '0;
      byte_sr  <= '0;
      word     <= '0;
    end else if (ss_rise) begin
      bit_cnt  <= '0;
      byte_idx <= '0;
      byte_sr  <= '0;
      word     <= '0;
    end else if (sck_rise && !ss_s) begin
      bit_cnt <= bit_cnt + 3'd1;
      byte_sr <= byte_new;
      if (bit_cnt == 3'd7) begin
        word[{byte_idx, 3'b000} +: 8] <= byte_new;
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  spi_slv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({byte_new, word[23:0]}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A new overrun in the same cycle as a software clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 overrun <= 1'b0;
    else if (push && full)   overrun <= 1'b1;
    else if (we && sel == REG_STATUS && wd[ST_OVERRUN]) overrun <= 1'b0;
  end

`ifdef SPI_SLV_PERIPH_TX_EN
  logic              sck_fall;
  logic              tx_wr;
  logic [WORD_W-1:0] tx_hold;
  logic [WORD_W-1:0] tx_sr;
  logic [4:0]        tx_ptr;

  assign sck_fall = ~sck_s & sck_d;
  assign tx_wr    = we & (sel == REG_TXDATA);

  // Position 0 of each word is driven live from tx_hold; the copy happens on the following fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold  <= '0;
      tx_sr    <= '0;
      tx_ptr   <= '0;
      tx_empty <= 1'b1;
      miso     <= 1'b0;
    end else begin
      if (ss_s) begin
        tx_ptr <= '0;
        miso   <= 1'b0;
      end else if (sck_fall) begin
        tx_ptr <= tx_ptr + 5'd1;
        if (tx_ptr == 5'd0) begin
          tx_sr    <= tx_hold;
          tx_empty <= 1'b1;
          miso     <= tx_hold[6];
        end else if (tx_ptr == 5'd31) begin
          miso <= tx_hold[7];
        end else begin
          miso <= tx_sr[tx_bit_idx(tx_ptr + 5'd1)];
        end
      end else if (tx_ptr == 5'd0) begin
        miso <= tx_hold[7];
      end
      if (tx_wr) begin
        tx_hold  <= wd;
        tx_empty <= 1'b0;
      end
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{wd[31:3], wd[1:0]};
  assign miso      = 1'b0;
  assign tx_empty  = 1'b1;
`endif

  always_comb begin
    rd = '0;
    case (sel)
      REG_RXDATA: rd = empty ? '0 : head;
      REG_STATUS: begin
        rd[ST_RX_VALID]           = ~empty;
        rd[ST_BUSY]               = ~ss_s;
        rd[ST_OVERRUN]            = overrun;
        rd[ST_TX_EMPTY]           = tx_empty;
        rd[ST_COUNT_LSB +: 4]     = 4'(count);
      end
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_slv_periph.sv
// Directed bench for spi_slv_periph; covers the TX path when SPI_SLV_PERIPH_TX_EN is defined.
module tb_spi_slv_periph;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst, sck, ss, mosi, miso, we, re;
  logic [31:0] addr, wd, rd;
  logic [31:0] popped, d;
  logic [7:0]  r0, r1, r2, r3;
  int          checks = 0;
  int          errors = 0;

  spi_slv_periph #(.FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .sck  (sck),
    .ss   (ss),
    .mosi (mosi),
    .miso (miso),
    .addr (addr),
    .we   (we),
    .re   (re),
    .wd   (wd),
    .rd   (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic do_pop, output logic [31:0] data);
    @(negedge clk);
    addr = a;
    re   = do_pop;
    #1 data = rd;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] data);
    @(negedge clk);
    addr = a;
    wd   = data;
    we   = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  // One mode-0 bit; with pop_here, RXDATA is popped on the clk edge that samples this rise.
  task automatic spi_bit(input logic b, input logic pop_here, output logic r);
    mosi = b;
    repeat (HALF) @(negedge clk);
    r   = miso;
    sck = 1'b1;
    if (pop_here) begin
      @(negedge clk);
      @(negedge clk);
      addr = 32'h0;
      re   = 1'b1;
      #1 popped = rd;
      @(negedge clk);
      re = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic pop_last, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], pop_last && (i == 0), r[i]);
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss = 1'b0;
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic pop_last);
    ss_low();
    spi_byte(w[7:0],   1'b0,     r0);
    spi_byte(w[15:8],  1'b0,     r1);
    spi_byte(w[23:16], 1'b0,     r2);
    spi_byte(w[31:24], pop_last, r3);
    ss_high();
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    we = 1'b0; re = 1'b0; addr = '0; wd = '0; popped = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    bus_rd(32'h4, 1'b0, d);   check("reset_status", d, 32'h08);
    bus_rd(32'h0, 1'b0, d);   check("reset_rxdata", d, 32'h0);
    check("reset_miso", {31'b0, miso}, 32'h0);

    // Basic word; busy is visible while selected.
    ss_low();
    repeat (6) @(negedge clk);
    bus_rd(32'h4, 1'b0, d);   check("busy", d, 32'h0A);
    spi_byte(8'hde, 1'b0, r0);
    spi_byte(8'hc0, 1'b0, r1);
    spi_byte(8'had, 1'b0, r2);
    spi_byte(8'hde, 1'b0, r3);
    ss_high();
    bus_rd(32'h4, 1'b0, d);   check("word1_status", d, 32'h19);
    bus_rd(32'h0, 1'b0, d);   check("word1_peek", d, 32'hdeadc0de);
    bus_rd(32'h0, 1'b1, d);   check("word1_pop", d, 32'hdeadc0de);
    bus_rd(32'h4, 1'b0, d);   check("word1_after_pop", d, 32'h08);
    bus_rd(32'h8, 1'b0, d);   check("txdata_reads_0", d, 32'h0);

    // Overrun: five words into a four-deep FIFO.
    for (int k = 1; k <= 5; k++) send_word({4{4'(k), 4'(k)}}, 1'b0);
    bus_rd(32'h4, 1'b0, d);   check("ovr_status", d, 32'h4D);
    for (int k = 1; k <= 4; k++) begin
      bus_rd(32'h0, 1'b1, d); check($sformatf("ovr_word%0d", k), d, {4{4'(k), 4'(k)}});
    end
    bus_rd(32'h4, 1'b0, d);   check("ovr_sticky", d, 32'h0C);
    bus_wr(32'hC, 32'hffffffff);
    bus_rd(32'hC, 1'b0, d);   check("rsvd_reads_0", d, 32'h0);
    bus_wr(32'h4, 32'h4);
    bus_rd(32'h4, 1'b0, d);   check("ovr_cleared", d, 32'h08);

    // Deselect after two bytes discards the partial word.
    ss_low();
    spi_byte(8'haa, 1'b0, r0);
    spi_byte(8'hbb, 1'b0, r1);
    ss_high();
    send_word(32'h04030201, 1'b0);
    bus_rd(32'h4, 1'b0, d);   check("partial_status", d, 32'h19);
    bus_rd(32'h0, 1'b1, d);   check("partial_word", d, 32'h04030201);

    // Pop in the same cycle as a push with two entries held.
    send_word(32'ha0a0a0a0, 1'b0);
    send_word(32'hb1b1b1b1, 1'b0);
    send_word(32'hc2c2c2c2, 1'b1);
    check("simul_popped", popped, 32'ha0a0a0a0);
    bus_rd(32'h4, 1'b0, d);   check("simul_status", d, 32'h29);
    bus_rd(32'h0, 1'b1, d);   check("simul_head1", d, 32'hb1b1b1b1);
    bus_rd(32'h0, 1'b1, d);   check("simul_head2", d, 32'hc2c2c2c2);

    // TX path.
    bus_wr(32'h8, 32'hc001beef);
`ifdef SPI_SLV_PERIPH_TX_EN
    bus_rd(32'h4, 1'b0, d);   check("tx_loaded", d, 32'h00);
    send_word(32'h12345678, 1'b0);
    check("tx_bytes", {r3, r2, r1, r0}, 32'hc001beef);
`else
    bus_rd(32'h4, 1'b0, d);   check("tx_ignored", d, 32'h08);
    send_word(32'h12345678, 1'b0);
    check("tx_bytes", {r3, r2, r1, r0}, 32'h0);
`endif
    bus_rd(32'h4, 1'b0, d);   check("tx_status", d, 32'h19);

    // Reset mid-byte with one word held and TX loaded; miso shows a 1 before reset when TX is on.
    ss_low();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0, r0[i]);
    bus_wr(32'h8, 32'hc001beef);
    addr = 32'h4;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_miso", {31'b0, miso}, 32'h0);
    check("rst_status", rd, 32'h08);
    ss = 1'b1; sck = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_word(32'hcafef00d, 1'b0);
    bus_rd(32'h4, 1'b0, d);   check("post_rst_status", d, 32'h19);
    bus_rd(32'h0, 1'b1, d);   check("post_rst_word", d, 32'hcafef00d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
